// File: rtl/compl_div.sv
// Sequential complex divider o = a / b in packed {I,Q} Q1.(W-1); restoring divide, one quotient bit per cycle.
// Latency W+3 cycles from accept to the out_valid strobe; in_ready is low while busy, and there is no output back-pressure.
module compl_div #(
  parameter int W = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic           out_valid,
  output logic [2*W-1:0] o,
  output logic           div_zero,
  output logic           sat
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W:0] MAX_POS = (W+1)'((2 ** (W - 1)) - 1);
  localparam logic [W:0] MAX_NEG = (W+1)'(2 ** (W - 1));

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t state, state_nx;

  logic [2*W-1:0] a_reg, b_reg;
  logic [2*W-1:0] den;
  logic [2*W+1:0] rem_i, rem_q;
  logic [W:0]     quo_i, quo_q;
  logic [CW-1:0]  cnt;
  logic           sign_i, sign_q, ovf_i, ovf_q, zero;

  // PREP arithmetic: numerator of a * conj(b), denominator |b|^2
  logic signed [W-1:0]   a_i, a_q, b_i, b_q;
  logic signed [2*W:0]   num_i, num_q;
  logic signed [2*W-1:0] sq_i, sq_q;
  logic [2*W-1:0]        den_c;
  logic [2*W:0]          mag_i, mag_q;

  assign a_i = a_reg[2*W-1:W];
  assign a_q = a_reg[W-1:0];
  assign b_i = b_reg[2*W-1:W];
  assign b_q = b_reg[W-1:0];

  assign num_i = (2*W+1)'(a_i) * (2*W+1)'(b_i) + (2*W+1)'(a_q) * (2*W+1)'(b_q);
  assign num_q = (2*W+1)'(a_q) * (2*W+1)'(b_i) - (2*W+1)'(a_i) * (2*W+1)'(b_q);
  assign sq_i  = (2*W)'(b_i) * (2*W)'(b_i);
  assign sq_q  = (2*W)'(b_q) * (2*W)'(b_q);
  assign den_c = $unsigned(sq_i) + $unsigned(sq_q);
  assign mag_i = num_i[2*W] ? $unsigned(-num_i) : $unsigned(num_i);
  assign mag_q = num_q[2*W] ? $unsigned(-num_q) : $unsigned(num_q);

  // One restoring step per DIV cycle, both components sharing den
  logic           bit_i, bit_q;
  logic [2*W+1:0] sub_i, sub_q;
  logic [W:0]     quo_i_fin, quo_q_fin;

  assign bit_i     = rem_i >= {2'b00, den};
  assign bit_q     = rem_q >= {2'b00, den};
  assign sub_i     = bit_i ? rem_i - {2'b00, den} : rem_i;
  assign sub_q     = bit_q ? rem_q - {2'b00, den} : rem_q;
  assign quo_i_fin = {quo_i[W-1:0], bit_i};
  assign quo_q_fin = {quo_q[W-1:0], bit_q};

  // Returns {sat, value}: round half away from zero, then clamp to the signed range.
  function automatic logic [W:0] form(input logic [W:0] q, input logic sgn, input logic ovf);
    logic [W+1:0] qp;
    logic [W:0]   m;
    logic [W:0]   nm;
    logic [W:0]   r;
    qp = {1'b0, q} + (W+2)'(1);
    m  = qp[W+1:1];
    nm = -m;
    if (!sgn) begin
      if (ovf || m > MAX_POS) r = {1'b1, MAX_POS[W-1:0]};
      else                    r = {1'b0, m[W-1:0]};
    end else begin
      if (ovf || m > MAX_NEG) r = {1'b1, MAX_NEG[W-1:0]};
      else                    r = {1'b0, nm[W-1:0]};
    end
    return r;
  endfunction

  logic [W:0] res_i, res_q;

  assign res_i = form(quo_i_fin, sign_i, ovf_i);
  assign res_q = form(quo_q_fin, sign_q, ovf_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = PREP;
      end
      PREP: state_nx = DIV;
      DIV:  if (cnt == '0) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      den      <= '0;
      rem_i    <= '0;
      rem_q    <= '0;
      quo_i    <= '0;
      quo_q    <= '0;
      cnt      <= '0;
      sign_i   <= 1'b0;
      sign_q   <= 1'b0;
      ovf_i    <= 1'b0;
      ovf_q    <= 1'b0;
      zero     <= 1'b0;
      o        <= '0;
      div_zero <= 1'b0;
      sat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        PREP: begin
          den    <= den_c;
          sign_i <= num_i[2*W];
          sign_q <= num_q[2*W];
          ovf_i  <= mag_i >= {den_c, 1'b0};
          ovf_q  <= mag_q >= {den_c, 1'b0};
          zero   <= den_c == '0;
          rem_i  <= {1'b0, mag_i};
          rem_q  <= {1'b0, mag_q};
          quo_i  <= '0;
          quo_q  <= '0;
          cnt    <= CW'(W);
        end
        DIV: begin
          rem_i <= {sub_i[2*W:0], 1'b0};
          rem_q <= {sub_q[2*W:0], 1'b0};
          quo_i <= quo_i_fin;
          quo_q <= quo_q_fin;
          if (cnt != '0) cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            if (zero) begin
              o        <= '0;
              div_zero <= 1'b1;
              sat      <= 1'b0;
            end else begin
              o        <= {res_i[W-1:0], res_q[W-1:0]};
              div_zero <= 1'b0;
              sat      <= res_i[W] | res_q[W];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compl_div.sv
// Scoreboard bench for compl_div: expected results are queued on accept and checked on the out_valid strobe.
module tb_compl_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] a, b;
  logic        out_valid;
  logic [39:0] o;
  logic        div_zero;
  logic        sat;

  compl_div #(.W(20)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .o(o), .div_zero(div_zero), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] o;
    logic        dz;
    logic        sat;
    longint      acc;
    real         fi;
    real         fq;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint last_acc = 0;
  logic   prev_ov = 1'b0;
  logic   stream_chk = 1'b0;
  logic   prev_stream = 1'b0;
  logic [39:0] last_o = '0;
  logic   last_dz = 1'b0;
  logic   last_sat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic chk_near(input string tag, input longint got, input real ideal);
    real d;
    d = real'(got) - ideal;
    n_cmp++;
    assert (d <= 1.0 && d >= -1.0) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%f (+-1)", tag, got, ideal);
    end
  endtask

  // Returns {sat, value} for one component of the quotient.
  function automatic logic [20:0] comp(input longint n, input longint den);
    longint mag, q, m, nm;
    logic   neg;
    neg = n < 0;
    mag = neg ? -n : n;
    if (mag == 0) return 21'd0;
    q = (mag <<< 20) / den;
    m = (q + 1) >>> 1;
    nm = -m;
    if (!neg) begin
      if (mag >= 2 * den || m > 524287) return {1'b1, 20'h7FFFF};
      return {1'b0, m[19:0]};
    end
    if (mag >= 2 * den || m > 524288) return {1'b1, 20'h80000};
    return {1'b0, nm[19:0]};
  endfunction

  function automatic exp_t model(input logic [39:0] aa, input logic [39:0] bb);
    exp_t   r;
    longint ai, aq, bi, bq, ni, nq, den;
    logic [20:0] ri, rq;
    ai = longint'($signed(aa[39:20]));
    aq = longint'($signed(aa[19:0]));
    bi = longint'($signed(bb[39:20]));
    bq = longint'($signed(bb[19:0]));
    ni = ai * bi + aq * bq;
    nq = aq * bi - ai * bq;
    den = bi * bi + bq * bq;
    r.o = '0; r.dz = 1'b0; r.sat = 1'b0; r.acc = 0; r.fi = 0.0; r.fq = 0.0;
    if (den == 0) begin
      r.dz = 1'b1;
    end else begin
      ri = comp(ni, den);
      rq = comp(nq, den);
      r.o   = {ri[19:0], rq[19:0]};
      r.sat = ri[20] | rq[20];
      r.fi  = real'(ni) / real'(den) * 524288.0;
      r.fq  = real'(nq) / real'(den) * 524288.0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      prev_ov = 1'b0;
      prev_stream = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (stream_chk && prev_stream) chk("accept_spacing", 64'(cyc - last_acc), 64'd24);
        prev_stream = stream_chk;
        last_acc = cyc;
        e = model(a, b);
        e.acc = cyc;
        sb.push_back(e);
      end
      if (out_valid) begin
        chk("strobe_single", 64'(prev_ov), 64'd0);
        chk("out_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("latency", 64'(cyc - e.acc), 64'd23);
          chk("o", 64'(o), 64'(e.o));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
          chk("sat", 64'(sat), 64'(e.sat));
          if (!e.sat && !e.dz) begin
            chk_near("float_i", longint'($signed(o[39:20])), e.fi);
            chk_near("float_q", longint'($signed(o[19:0])), e.fq);
          end
        end
        last_o = o;
        last_dz = div_zero;
        last_sat = sat;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [39:0] aa, input logic [39:0] bb);
    in_valid = 1'b1;
    a = aa;
    b = bb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [19:0] rnd_small();
    logic [19:0] t;
    t = 20'($urandom);
    return {{2{t[19]}}, t[19:2]};
  endfunction

  initial begin
    int     busy;
    longint oi, oq, bi, bq;
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;

    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_o", 64'(o), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 0.25 / 0.5
    send(40'h20000_00000, 40'h40000_00000);
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      busy++;
    end
    chk("busy_cycles", 64'(busy), 64'd23);
    drain();
    chk("half_o", 64'(last_o), 64'h40000_00000);
    chk("half_sat", 64'(last_sat), 64'd0);
    chk("half_dz", 64'(last_dz), 64'd0);

    // (0.125+0.0625j)/(0.5+0.5j); multiplying back must return a
    send(40'h10000_08000, 40'h40000_40000);
    drain();
    chk("cplx_o", 64'(last_o), 64'h18000_F8000);
    oi = longint'($signed(last_o[39:20]));
    oq = longint'($signed(last_o[19:0]));
    bi = 64'h40000;
    bq = 64'h40000;
    chk("mult_back_i", 64'((oi * bi - oq * bq) >>> 19), 64'h10000);
    chk("mult_back_q", 64'((oi * bq + oq * bi) >>> 19), 64'h08000);

    send(40'h40000_00000, 40'h20000_00000);
    drain();
    chk("ovf_pos_o", 64'(last_o), 64'h7FFFF_00000);
    chk("ovf_pos_sat", 64'(last_sat), 64'd1);

    send(40'hC0000_00000, 40'h20000_00000);
    drain();
    chk("ovf_neg_o", 64'(last_o), 64'h80000_00000);
    chk("ovf_neg_sat", 64'(last_sat), 64'd1);

    send(40'h12345_54321, 40'h0);
    drain();
    chk("dz_o", 64'(last_o), 64'd0);
    chk("dz_flag", 64'(last_dz), 64'd1);
    chk("dz_sat", 64'(last_sat), 64'd0);

    // in_valid held high with operands changing every cycle
    stream_chk = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = {rnd_small(), rnd_small()};
      b = 40'($urandom) ^ {8'($urandom), 32'h0};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    stream_chk = 1'b0;
    drain();

    // back-to-back random vectors
    for (int i = 0; i < 20; i++) begin
      send({rnd_small(), rnd_small()}, {20'($urandom), 20'($urandom)});
    end
    drain();

    // reset 10 cycles into DIV aborts the operation
    send(40'h20000_00000, 40'h40000_00000);
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_o", 64'(o), 64'd0);
    chk("abort_div_zero", 64'(div_zero), 64'd0);
    chk("abort_sat", 64'(sat), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    send(40'h10000_08000, 40'h40000_40000);
    drain();
    chk("post_rst_o", 64'(last_o), 64'h18000_F8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/compl_div.md
# compl_div

Sequential fixed-point complex divider, o = a / b, the inverse of the DPD datapath's complex multiplier; it uses the same packed {I,Q} Q1.(W-1) format, so its outputs feed that multiplier directly. It is used to compute DPD gain-correction coefficients, such as reference / measured, at a low, non-streaming rate. Each division runs as a multi-cycle restoring divider, producing one quotient bit per cycle for I and Q in parallel. Transfers use a valid/ready input handshake and a one-cycle output strobe.

## Interface
- W, 20: width of each I and Q component, in signed Q1.(W-1).
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  divider idle; a transfer occurs on in_valid & in_ready.
- a  in  2W  dividend, packed {a_i[2W-1:W], a_q[W-1:0]}.
- b  in  2W  divisor, same packing.
- out_valid  out  1  one-cycle strobe; o, div_zero and sat are valid.
- o  out  2W  quotient, packed {o_i, o_q}, Q1.(W-1).
- div_zero  out  1  b was 0+0j.
- sat  out  1  o_i or o_q was saturated.

## Operation
- FSM states: IDLE, PREP, DIV, DONE.
- **IDLE**
  - in_ready = 1.
  - On a transfer, register a and b, then go to PREP.
  - in_valid while not in IDLE is ignored and is not queued.
- **PREP** (1 cycle), all arithmetic signed and full-width:
  - num_i = a_i·b_i + a_q·b_q (2W+1 bits).
  - num_q = a_q·b_i − a_i·b_q (2W+1 bits).
  - den = b_i² + b_q², unsigned, 2W bits; maximum 2^(2W-1).
  - Store sign_i/sign_q and magnitudes |num_i|/|num_q|.
  - ovf_x = (|num_x| ≥ 2·den).
  - zero = (den == 0).
- **DIV** (exactly W+1 cycles, counter W down to 0)
  - Restoring division of |num_x|·2^W by den, for I and Q in parallel, sharing den.
  - Remainder width is 2W+2.
  - Produces an unsigned quotient q_x < 2^(W+1) when ovf_x = 0.
  - Always runs the full count, even when zero or ovf is set, so latency is fixed.
- **DONE** (1 cycle): out_valid = 1, then return to IDLE.
- Result formation on the DIV→DONE edge:
  - Rounding: m_x = (q_x + 1) >> 1, i.e. round half away from zero on the magnitude.
  - Positive result: m_x > 2^(W-1)−1 or ovf_x → o_x = 2^(W-1)−1, sat = 1.
  - Negative result: m_x > 2^(W-1) or ovf_x → o_x = −2^(W-1), sat = 1.
  - Otherwise o_x = sign_x ? −m_x : m_x.
  - A zero magnitude always gives o_x = 0, never −0 saturation.
  - zero = 1 → o = 0, div_zero = 1, sat = 0.
- o, div_zero and sat hold their values from DONE until the next DONE.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, o = 0, div_zero = 0, sat = 0, counter = 0.
- Reset mid-operation aborts the division. No out_valid is produced for the aborted operand; the first cycle after release is IDLE.
- Latency, with the accept cycle as T:
  - T+1: PREP.
  - T+2 … T+W+2: DIV.
  - T+W+3: DONE (out_valid = 1); 23 cycles for W = 20.
- in_ready = 0 from T+1 through DONE, and 1 again from T+W+4.
- Throughput: one division per W+4 cycles when in_valid is held high.
- out_valid is never high for two consecutive cycles. There is no output back-pressure: the consumer must take o on the strobe.
- Operands are captured at T; later changes to a or b do not affect the result.

## Test plan
- a = {0x20000, 0}, b = {0x40000, 0}, i.e. 0.25/0.5:
  - o = {0x40000, 0x00000}, sat = 0, div_zero = 0.
  - out_valid exactly 23 cycles after accept.
  - in_ready low for 23 cycles.
- a = {0x10000, 0x08000}, b = {0x40000, 0x40000}, i.e. (0.125+0.0625j)/(0.5+0.5j):
  - o = {0x18000, 0xF8000}.
  - Feeding o and b to the complex multiplier returns a.
- Overflow: a = {0x40000, 0}, b = {0x20000, 0}:
  - o = {0x7FFFF, 0}, sat = 1.
  - With a = {0xC0000, 0}: o = {0x80000, 0}, sat = 1.
- Divide by zero: a = {0x12345, 0x54321}, b = 0:
  - o = 0, div_zero = 1, sat = 0.
  - Latency still 23 cycles.
- Busy behaviour:
  - Hold in_valid high with changing a and b: exactly one accept every 24 cycles; each result matches the operands sampled on its accept cycle.
  - Back-to-back random-vector run: all outputs are within 1 LSB of a floating-point model, and exact where rounding has no tie.
- Reset asserted 10 cycles into DIV:
  - All outputs return to reset values asynchronously.
  - No out_valid for the aborted operation.
  - The next operation completes normally with 23-cycle latency.
